// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   state_e   : arbiter sequencing states (idle, access in flight, completion cycle)
//   owner_e   : which pipeline stage owns the current access (IF = 0, DM = 1)
//   Default*  : default starvation limit and access timeout
//   cnt_width : bits needed to hold a counter value in 0..max_val
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } owner_e;

  localparam int unsigned DefaultStarveMax = 4;
  localparam int unsigned DefaultTimeout   = 15;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clear/enable up-counter with terminal-count flag, used as the access timeout.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset
//   clr_i   : clear count to zero (wins over en_i)
//   en_i    : count one more cycle
//   tc_o    : high while the count sits at Limit-1, i.e. the next counted cycle
//             would reach Limit
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned Limit = DefaultTimeout
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = cnt_width(Limit);
  localparam logic [CntW-1:0] LastVal = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch (IF) and
// data-memory (DM) pipeline stages over a variable-latency req/ack handshake.
// Ports:
//   clk, reset               : clock and synchronous active-high reset
//   if_req/if_addr           : fetch request (level) and address
//   if_rdata/if_valid        : registered fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request, direction, address, store data
//   dm_rdata/dm_valid        : registered load data and one-cycle completion pulse
//   stall                    : pipeline stall while any requester waits
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_rdata/mem_ack        : memory read data and single-cycle completion
//   err                      : sticky timeout flag
// Each access takes IDLE -> ACCESS (>=1 cycle) -> DONE (1 cycle). DM has
// priority, but IF is forced after STARVE_MAX consecutive DM grants during
// which IF was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = DefaultStarveMax,
  parameter int unsigned TIMEOUT    = DefaultTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int unsigned StarveW = cnt_width(STARVE_MAX);
  localparam logic [StarveW-1:0] StarveMaxV = StarveW'(STARVE_MAX);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic                err_q, err_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;

  logic                dm_win;
  logic                if_win;
  logic                timer_clr;
  logic                timer_en;
  logic                timer_tc;

  mem_arb_timer #(
    .Limit (TIMEOUT)
  ) u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .tc_o    (timer_tc)
  );

  // IF is forced only when it is waiting and DM has already had its quota.
  assign dm_win = dm_req && !(if_req && (starve_cnt_q == StarveMaxV));
  assign if_win = !dm_win && if_req;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    err_d        = err_q;
    starve_cnt_d = starve_cnt_q;
    timer_clr    = 1'b1;
    timer_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dm_win) begin
          owner_d     = OwnDm;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = StAccess;
          if (if_req) begin
            starve_cnt_d = (starve_cnt_q == StarveMaxV) ? StarveMaxV
                                                         : starve_cnt_q + 1'b1;
          end else begin
            starve_cnt_d = '0;
          end
        end else if (if_win) begin
          owner_d      = OwnIf;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          state_d      = StAccess;
          starve_cnt_d = '0;
        end
      end

      StAccess: begin
        timer_clr = 1'b0;
        // An ack on the terminal cycle takes priority over the timeout.
        if (mem_ack) begin
          if (!mem_we_q) begin
            if (owner_q == OwnIf) begin
              if_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = mem_rdata;
            end
          end
          mem_req_d  = 1'b0;
          state_d    = StDone;
          if_valid_d = (owner_q == OwnIf);
          dm_valid_d = (owner_q == OwnDm);
        end else if (timer_tc) begin
          if (!mem_we_q) begin
            if (owner_q == OwnIf) begin
              if_rdata_d = '0;
            end else begin
              dm_rdata_d = '0;
            end
          end
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          state_d    = StDone;
          if_valid_d = (owner_q == OwnIf);
          dm_valid_d = (owner_q == OwnDm);
        end else begin
          timer_en = 1'b1;
        end
      end

      StDone: begin
        // Requests are deliberately not sampled here.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign err       = err_q;

  // A requester stops stalling in its own valid cycle.
  assign stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// a transaction-level model compared against the DUT outputs every cycle.
module tb_mem_port_arbiter;

  localparam int unsigned StarveMax = 4;
  localparam int unsigned Timeout   = 15;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_valid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int total;
  int bad;
  int cyc;

  // Memory responder controls: ack on the ack_delay-th cycle of mem_req
  // (0 = never); force_ack injects a stray ack.
  int          ack_delay;
  logic [15:0] rdata_val;
  bit          force_ack;

  logic [15:0] grant_log[$];

  mem_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .STARVE_MAX (StarveMax),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Memory responder.
  initial begin
    int req_age;
    req_age   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req === 1'b1) req_age++;
      else req_age = 0;
      mem_ack   = force_ack || (ack_delay != 0 && req_age == ack_delay);
      mem_rdata = rdata_val;
    end
  end

  // Transaction-level model and per-cycle compare.
  initial begin
    bit          model_on, busy, showing;
    bit          own_dm;
    int          age;
    int          streak;
    bit          prev_req;
    logic        e_mem_req, e_mem_we, e_if_valid, e_dm_valid, e_err, e_stall;
    logic [15:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata, got;
    model_on = 0;
    prev_req = 0;
    cyc      = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        model_on = 1;
        busy = 0; showing = 0; own_dm = 0; age = 0; streak = 0;
        e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
        e_if_valid = 0; e_dm_valid = 0; e_if_rdata = '0; e_dm_rdata = '0; e_err = 0;
      end else if (model_on) begin
        e_if_valid = 0;
        e_dm_valid = 0;
        if (showing) begin
          showing = 0;
        end else if (!busy) begin
          // IF gets its turn once it has watched StarveMax DM grants go by.
          if (dm_req && !(if_req && streak == StarveMax)) begin
            busy = 1; own_dm = 1; age = 0;
            e_mem_req = 1; e_mem_we = dm_we; e_mem_addr = dm_addr; e_mem_wdata = dm_wdata;
            streak = if_req ? ((streak + 1 > StarveMax) ? StarveMax : streak + 1) : 0;
          end else if (if_req) begin
            busy = 1; own_dm = 0; age = 0;
            e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr; e_mem_wdata = '0;
            streak = 0;
          end
        end else begin
          age++;
          if (mem_ack || age == Timeout) begin
            got = mem_ack ? mem_rdata : 16'h0000;
            if (!mem_ack) e_err = 1;
            if (!e_mem_we) begin
              if (own_dm) e_dm_rdata = got;
              else e_if_rdata = got;
            end
            e_if_valid = !own_dm;
            e_dm_valid = own_dm;
            e_mem_req = 0;
            busy = 0;
            showing = 1;
          end
        end
      end
      #1;
      if (model_on) begin
        e_stall = (if_req & ~e_if_valid) | (dm_req & ~e_dm_valid);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_mem_req});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_mem_we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, e_mem_addr});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_mem_wdata});
        chk("if_valid", {31'd0, if_valid}, {31'd0, e_if_valid});
        chk("dm_valid", {31'd0, dm_valid}, {31'd0, e_dm_valid});
        chk("if_rdata", {16'd0, if_rdata}, {16'd0, e_if_rdata});
        chk("dm_rdata", {16'd0, dm_rdata}, {16'd0, e_dm_rdata});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        if (mem_req === 1'b1 && !prev_req) grant_log.push_back(mem_addr);
        prev_req = (mem_req === 1'b1);
      end
    end
  end

  task automatic wait_valid(input string nm, input bit dm, input int budget,
                            output int nclk, output int rc);
    nclk = 0;
    rc   = 0;
    do begin
      @(negedge clk);
      nclk++;
      if (mem_req === 1'b1) rc++;
    end while (!((dm ? dm_valid : if_valid) === 1'b1) && nclk < budget);
    total++;
    if (!((dm ? dm_valid : if_valid) === 1'b1)) begin
      bad++;
      $display("FAIL %s_timeout: valid not seen within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    int n, rc;
    total = 0; bad = 0;
    reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; ack_delay = 1; rdata_val = '0; force_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single IF read, zero wait.
    rdata_val = 16'h1234; if_addr = 16'h0010; if_req = 1;
    #1 chk("t1_stall_N", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", {16'd0, mem_addr}, 32'h0010);
    chk("t1_stall_N1", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("t1_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_if_rdata", {16'd0, if_rdata}, 32'h1234);
    chk("t1_stall_N2", {31'd0, stall}, 32'd0);
    if_req = 0;
    repeat (2) @(negedge clk);

    // 2: simultaneous requests, DM write wins first.
    rdata_val = 16'h5555; if_addr = 16'h0020; if_req = 1;
    dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    chk("t2_mem_addr", {16'd0, mem_addr}, 32'h0200);
    @(negedge clk);
    chk("t2_dm_valid", {31'd0, dm_valid}, 32'd1);
    chk("t2_dm_rdata", {16'd0, dm_rdata}, 32'h0000);
    dm_req = 0; dm_we = 0;
    wait_valid("t2_if", 0, 10, n, rc);
    chk("t2_if_gap", n, 32'd3);
    chk("t2_if_rdata", {16'd0, if_rdata}, 32'h5555);
    if_req = 0;
    repeat (2) @(negedge clk);

    // 3: starvation limit.
    grant_log.delete();
    if_addr = 16'h0100; dm_addr = 16'h0300; dm_we = 0; rdata_val = 16'h0F0F;
    if_req = 1; dm_req = 1;
    n = 0;
    while (grant_log.size() < 10 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t3_grants", grant_log.size() >= 10, 32'd1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      chk($sformatf("t3_grant%0d", i), {16'd0, grant_log[i]},
          (i % 5 == 4) ? 32'h0100 : 32'h0300);
    end
    if_req = 0; dm_req = 0;
    repeat (5) @(negedge clk);

    // 4: DM read with 5 wait cycles.
    ack_delay = 5; rdata_val = 16'hA5A5; dm_addr = 16'h0400; dm_we = 0; dm_req = 1;
    wait_valid("t4_dm", 1, 20, n, rc);
    chk("t4_req_cycles", rc, 32'd5);
    chk("t4_dm_rdata", {16'd0, dm_rdata}, 32'hA5A5);
    chk("t4_err", {31'd0, err}, 32'd0);
    dm_req = 0;
    repeat (2) @(negedge clk);

    // Ack on the same cycle the timeout would fire counts as an ack.
    ack_delay = 15; rdata_val = 16'h7777; dm_addr = 16'h0440; dm_req = 1;
    wait_valid("tb_dm", 1, 30, n, rc);
    chk("tb_req_cycles", rc, 32'd15);
    chk("tb_dm_rdata", {16'd0, dm_rdata}, 32'h7777);
    chk("tb_err", {31'd0, err}, 32'd0);
    dm_req = 0;
    repeat (2) @(negedge clk);

    // 5: IF read timeout.
    ack_delay = 0; if_addr = 16'h0500; if_req = 1;
    wait_valid("t5_if", 0, 30, n, rc);
    chk("t5_req_cycles", rc, 32'd15);
    chk("t5_if_rdata", {16'd0, if_rdata}, 32'h0000);
    chk("t5_err", {31'd0, err}, 32'd1);
    if_req = 0;
    repeat (2) @(negedge clk);
    ack_delay = 1; dm_we = 1; dm_addr = 16'h0510; dm_wdata = 16'h1111; dm_req = 1;
    wait_valid("t5_dm", 1, 10, n, rc);
    chk("t5_err_sticky", {31'd0, err}, 32'd1);
    dm_req = 0; dm_we = 0;
    repeat (2) @(negedge clk);

    // 6: reset in the second access cycle.
    ack_delay = 0; if_addr = 16'h0600; if_req = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1; if_req = 0;
    @(negedge clk);
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_valids", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    reset = 0; force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    @(negedge clk);
    chk("t6_late_ack", {29'd0, mem_req, if_valid, dm_valid}, 32'd0);
    ack_delay = 1; rdata_val = 16'h4321; if_addr = 16'h0700; if_req = 1;
    wait_valid("t6_if", 0, 10, n, rc);
    chk("t6_if_lat", n, 32'd2);
    chk("t6_if_rdata", {16'd0, if_rdata}, 32'h4321);
    if_req = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
